// File: rtl/cpu_seq.sv
// Sequential CPU core: NREG x W register file, carry/zero flags, one instruction per
// valid/ready handshake, multi-cycle shift-add multiply and a sticky HALT state.
module cpu_seq #(
   parameter  int W    = 8,
   parameter  int NREG = 4,
   localparam int AW   = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [3:0]    in_op,
   input  logic [AW-1:0] in_rd,
   input  logic [AW-1:0] in_rs,
   input  logic [W-1:0]  in_imm,
   input  logic [AW-1:0] dbg_sel,
   output logic [W-1:0]  dbg_data,
   output logic          carry,
   output logic          zero,
   output logic          busy,
   output logic          halted,
   output logic          done
);

   localparam int CW = (W > 2) ? $clog2(W) : 1;

   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_MOV  = 4'd1;
   localparam logic [3:0] OP_ADD  = 4'd2;
   localparam logic [3:0] OP_ADC  = 4'd3;
   localparam logic [3:0] OP_SUB  = 4'd4;
   localparam logic [3:0] OP_AND  = 4'd5;
   localparam logic [3:0] OP_OR   = 4'd6;
   localparam logic [3:0] OP_XOR  = 4'd7;
   localparam logic [3:0] OP_NOT  = 4'd8;
   localparam logic [3:0] OP_SHL  = 4'd9;
   localparam logic [3:0] OP_SHR  = 4'd10;
   localparam logic [3:0] OP_LDI  = 4'd11;
   localparam logic [3:0] OP_INC  = 4'd12;
   localparam logic [3:0] OP_DEC  = 4'd13;
   localparam logic [3:0] OP_MUL  = 4'd14;
   localparam logic [3:0] OP_HALT = 4'd15;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_HALT} state_t;

   state_t          state_q,  state_d;
   logic [W-1:0]    reg_q [NREG];
   logic [W-1:0]    reg_d [NREG];
   logic            carry_q,  carry_d;
   logic            zero_q,   zero_d;
   logic            done_q,   done_d;
   logic [CW-1:0]   cnt_q,    cnt_d;
   logic [2*W-1:0]  acc_q,    acc_d;
   logic [2*W-1:0]  mcand_q,  mcand_d;
   logic [W-1:0]    mplier_q, mplier_d;
   logic [AW-1:0]   mul_rd_q, mul_rd_d;

   logic [W-1:0]    rd_v, rs_v, res;
   logic [W:0]      wide;
   logic [2*W-1:0]  acc_n;
   logic            accept;

   assign in_ready = rst_n && (state_q == S_IDLE);
   assign accept   = in_valid && in_ready;
   assign dbg_data = reg_q[dbg_sel];
   assign carry    = carry_q;
   assign zero     = zero_q;
   assign busy     = (state_q == S_MUL);
   assign halted   = (state_q == S_HALT);
   assign done     = done_q;

   assign rd_v  = reg_q[in_rd];
   assign rs_v  = reg_q[in_rs];
   assign acc_n = acc_q + (mplier_q[0] ? mcand_q : '0);

   always_comb begin
      state_d  = state_q;
      reg_d    = reg_q;
      carry_d  = carry_q;
      zero_d   = zero_q;
      done_d   = 1'b0;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      mul_rd_d = mul_rd_q;
      res      = '0;
      wide     = '0;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               done_d = 1'b1;
               case (in_op)
                  OP_MOV: reg_d[in_rd] = rs_v;
                  OP_ADD, OP_ADC: begin
                     wide = {1'b0, rd_v} + {1'b0, rs_v}
                          + {{W{1'b0}}, (in_op == OP_ADC) ? carry_q : 1'b0};
                     res  = wide[W-1:0];
                     carry_d = wide[W];
                  end
                  OP_SUB: begin
                     wide = {1'b0, rd_v} - {1'b0, rs_v};
                     res  = wide[W-1:0];
                     carry_d = wide[W];
                  end
                  OP_AND: res = rd_v & rs_v;
                  OP_OR:  res = rd_v | rs_v;
                  OP_XOR: res = rd_v ^ rs_v;
                  OP_NOT: res = ~rd_v;
                  OP_SHL: begin
                     res     = {rd_v[W-2:0], 1'b0};
                     carry_d = rd_v[W-1];
                  end
                  OP_SHR: begin
                     res     = {1'b0, rd_v[W-1:1]};
                     carry_d = rd_v[0];
                  end
                  OP_LDI: reg_d[in_rd] = in_imm;
                  OP_INC: begin
                     wide = {1'b0, rd_v} + {{W{1'b0}}, 1'b1};
                     res  = wide[W-1:0];
                     carry_d = wide[W];
                  end
                  OP_DEC: begin
                     wide = {1'b0, rd_v} - {{W{1'b0}}, 1'b1};
                     res  = wide[W-1:0];
                     carry_d = wide[W];
                  end
                  OP_MUL: begin
                     done_d   = 1'b0;
                     state_d  = S_MUL;
                     cnt_d    = '0;
                     acc_d    = '0;
                     mcand_d  = {{W{1'b0}}, rd_v};
                     mplier_d = rs_v;
                     mul_rd_d = in_rd;
                  end
                  OP_HALT: state_d = S_HALT;
                  default: ;
               endcase
               // Ops that produce an ALU result write rd and update Z
               if ((in_op >= OP_ADD && in_op <= OP_SHR) || in_op == OP_INC || in_op == OP_DEC) begin
                  reg_d[in_rd] = res;
                  zero_d       = (res == '0);
               end
            end
         end
         S_MUL: begin
            acc_d    = acc_n;
            mcand_d  = {mcand_q[2*W-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[W-1:1]};
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CW'(W - 1)) begin
               reg_d[mul_rd_q] = acc_n[W-1:0];
               carry_d = (acc_n[2*W-1:W] != '0);
               zero_d  = (acc_n[W-1:0] == '0);
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         for (int i = 0; i < NREG; i++) reg_q[i] <= '0;
         carry_q  <= 1'b0;
         zero_q   <= 1'b0;
         done_q   <= 1'b0;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         mul_rd_q <= '0;
      end else begin
         state_q  <= state_d;
         reg_q    <= reg_d;
         carry_q  <= carry_d;
         zero_q   <= zero_d;
         done_q   <= done_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         mul_rd_q <= mul_rd_d;
      end
   end

endmodule

// File: doc/cpu_seq.md
# cpu_seq

Parametrised sequential successor to the 8-bit combinational CPU datapath. It holds a register file of `NREG` general registers of `W` bits plus carry and zero flags. It accepts one instruction per valid/ready handshake and executes most ops in a single cycle. Multiply is a multi-cycle shift-add sequence, and a HALT state holds until reset. It sits between an instruction source (sequencer or testbench) and the register/flag observers.

## Interface
- `W`, 8: data width of registers, immediate and ALU; ≥2.
- `NREG`, 4: number of registers; power of two, ≥2; `AW = clog2(NREG)` is derived, not a parameter.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  instruction present.
- `in_ready`  out  1  core can accept; transfer occurs on an edge with `in_valid & in_ready`.
- `in_op`  in  4  opcode.
- `in_rd`  in  AW  destination/first-operand register index.
- `in_rs`  in  AW  source register index.
- `in_imm`  in  W  immediate, used by LDI only.
- `dbg_sel`  in  AW  register select for debug read.
- `dbg_data`  out  W  combinational read of `reg[dbg_sel]`.
- `carry`  out  1  carry/borrow flag.
- `zero`  out  1  zero flag.
- `busy`  out  1  high in MUL state.
- `halted`  out  1  high in HALT state.
- `done`  out  1  one-cycle pulse: previous instruction's result is now visible.

## Operation
- States: IDLE, MUL, HALT. Reset → IDLE.
- In IDLE: `in_ready=1`; in MUL and HALT, and while `rst_n=0`: `in_ready=0`.
- Opcodes (rd=reg[in_rd], rs=reg[in_rs], results truncated to W bits):
  - 0 NOP: no effect.
  - 1 MOV: rd←rs.
  - 2 ADD: rd←rd+rs; C←carry out.
  - 3 ADC: rd←rd+rs+C; C←carry out.
  - 4 SUB: rd←rd−rs; C←borrow (rd<rs).
  - 5 AND, 6 OR, 7 XOR: rd←rd op rs.
  - 8 NOT: rd←~rd.
  - 9 SHL: C←rd[W−1]; rd←rd<<1.
  - 10 SHR: C←rd[0]; rd←rd>>1 (logical).
  - 11 LDI: rd←in_imm.
  - 12 INC: rd←rd+1; C←(rd was all-ones).
  - 13 DEC: rd←rd−1; C←(rd was 0).
  - 14 MUL: operands latched at accept; go to MUL. Shift-add over W iterations. At completion, rd←low W bits; C←(high W bits ≠0).
  - 15 HALT: go to HALT.
- Flags:
  - Z←(result==0) for ops 2–10, 12–14.
  - NOP, MOV, LDI and HALT leave both flags unchanged.
  - AND/OR/XOR/NOT leave C unchanged.
- `rd==rs` is legal for all ops; it uses the pre-instruction value of both operands (MUL squares).
- HALT: `halted=1` and `in_ready=0` until reset; inputs are ignored.

## Timing
- Reset (edge with `rst_n=0`): all registers 0, C=0, Z=0, state IDLE, `busy=0`, `halted=0`, `done=0`, MUL counter/accumulator cleared.
- `dbg_data` is combinational and valid during reset.
- Single-cycle op accepted at edge k:
  - Register and flags update at edge k.
  - `done=1` during cycle k+1.
  - Core stays in IDLE, so back-to-back accepts occur every cycle.
- MUL accepted at edge k:
  - `busy=1` and `in_ready=0` for exactly W cycles (edges k+1..k+W are iterations).
  - Result and flags are written at edge k+W.
  - `done=1` and `in_ready=1` during cycle k+W+1.
- HALT accepted at edge k: `done=1` and `halted=1` from cycle k+1.
- `done` is registered; never high for two cycles from a single instruction.
- Reset mid-MUL or in HALT aborts immediately. No partial result is written and no `done` is issued.
- `in_valid` while `in_ready=0`: no effect; the source must hold the instruction.

## Test plan
- Reset: hold `rst_n=0` for 2 cycles, release → all `dbg_data` 0, `carry=0`, `zero=0`, `in_ready=1`, `done=0`.
- ADD/ADC: LDI A=0xCC, B=0x55; ADD A,B → A=0x21, C=1, Z=0. LDI C=0x0F, D=0xF0; ADC C,D → C=0x00, carry=1, Z=1.
- SUB borrow: LDI A=0x06, B=0x08; SUB A,B → A=0xFE, C=1. SUB B,B → B=0x00, C=0, Z=1.
- Back-to-back: `in_valid` held 4 cycles issuing LDI A=0xFF, INC A, SHL A, SHR A → accepted on 4 consecutive edges.
  - After INC: A=0x00, C=1, Z=1.
  - After SHL: A=0x00, C=0, Z=1.
  - `done` high 4 consecutive cycles.
- MUL: A=0x10, B=0x20; MUL A,B → `in_ready` low exactly 8 cycles, A=0x00, C=1, Z=1, single `done` pulse. Repeat with A=0x0D, B=0x0D, MUL A,A → A=0xA9, C=0.
- Abort/halt:
  - Reset asserted at iteration 3 of MUL → A unchanged-then-0, no `done`, IDLE next.
  - HALT → `halted=1`, further LDI ignored, registers unchanged until reset.
